// File: rtl/mem_arbiter_pkg.sv
// Shared memory-access types plus the port/alignment helpers used by the
// fetch/data arbiter in front of the single-ported memory.
package definitions;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } mem_access_size_t;

    typedef enum logic {
        ARB_PORT_FETCH,
        ARB_PORT_DATA
    } arb_port_t;

    localparam int NUM_PORTS = 2;

    function automatic logic mem_is_aligned(input logic [1:0] addr, input mem_access_size_t size);
        case (size)
            WORD:    return addr == 2'b00;
            HALF:    return addr[0] == 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    // Keeps only the bytes a load of this size actually returns.
    function automatic logic [31:0] mem_size_mask(input mem_access_size_t size);
        case (size)
            BYTE:    return 32'h0000_00FF;
            HALF:    return 32'h0000_FFFF;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/mem_if.sv
// Bus toward the single-ported memory: combinational read, write commits on posedge.
interface mem_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    import definitions::*;

    logic [ADDR_W-1:0] rd_addr;
    mem_access_size_t  rd_size;
    logic [DATA_W-1:0] rd_data;
    logic              wr_enable;
    logic [ADDR_W-1:0] wr_addr;
    mem_access_size_t  wr_size;
    logic [DATA_W-1:0] wr_data;

    modport slave  (output rd_addr, rd_size, wr_enable, wr_addr, wr_size, wr_data, input rd_data);
    modport master (input rd_addr, rd_size, wr_enable, wr_addr, wr_size, wr_data, output rd_data);

endinterface

// File: rtl/mem_resp_slot.sv
// One-entry response register for a requester port; holds its contents until consumed.
module mem_resp_slot #(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              load,
    input  logic [DATA_W-1:0] load_rdata,
    input  logic              load_err,
    input  logic              resp_ready,
    output logic              valid,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              can_accept
);

    // A consume in the same cycle frees the slot for a back-to-back reload.
    assign can_accept = !valid || resp_ready;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            valid <= 1'b0;
            rdata <= '0;
            err   <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            rdata <= load_rdata;
            err   <= load_err;
        end else if (resp_ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data front end for the single-ported memory: one grant per cycle,
// alignment check, registered responses. Define MEM_ARB_ROUND_ROBIN_EN to
// alternate ties; otherwise data always wins ties.
module mem_arbiter
    import definitions::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              if_req_valid_i,
    output logic              if_req_ready_o,
    input  logic [ADDR_W-1:0] if_req_addr_i,
    output logic              if_resp_valid_o,
    input  logic              if_resp_ready_i,
    output logic [DATA_W-1:0] if_resp_rdata_o,
    output logic              if_resp_err_o,
    input  logic              d_req_valid_i,
    output logic              d_req_ready_o,
    input  logic [ADDR_W-1:0] d_req_addr_i,
    input  mem_access_size_t  d_req_size_i,
    input  logic              d_req_we_i,
    input  logic [DATA_W-1:0] d_req_wdata_i,
    output logic              d_resp_valid_o,
    input  logic              d_resp_ready_i,
    output logic [DATA_W-1:0] d_resp_rdata_o,
    output logic              d_resp_err_o,
    mem_if.slave              memif
);

    logic [NUM_PORTS-1:0]             req_valid, resp_ready, elig, slot_load;
    logic [NUM_PORTS-1:0]             slot_valid, slot_err, slot_can;
    logic [NUM_PORTS-1:0][DATA_W-1:0] slot_rdata;
    logic                             grant_any, tie_to_fetch, aligned, req_we, do_rd, do_wr;
    arb_port_t                        winner;
    logic [ADDR_W-1:0]                req_addr;
    mem_access_size_t                 req_size;
    logic [DATA_W-1:0]                load_rdata;

    assign req_valid  = {d_req_valid_i, if_req_valid_i};
    assign resp_ready = {d_resp_ready_i, if_resp_ready_i};
    // Gating with reset keeps both ready outputs low while reset is held.
    assign elig       = req_valid & slot_can & {NUM_PORTS{reset_n_i}};
    assign grant_any  = |elig;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    arb_port_t last_grant;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)     last_grant <= ARB_PORT_FETCH;
        else if (grant_any) last_grant <= winner;
    end

    assign tie_to_fetch = (last_grant == ARB_PORT_DATA);
`else
    assign tie_to_fetch = 1'b0;
`endif

    assign winner = (elig[ARB_PORT_FETCH] && (!elig[ARB_PORT_DATA] || tie_to_fetch))
                  ? ARB_PORT_FETCH : ARB_PORT_DATA;

    assign slot_load[ARB_PORT_FETCH] = grant_any && (winner == ARB_PORT_FETCH);
    assign slot_load[ARB_PORT_DATA]  = grant_any && (winner == ARB_PORT_DATA);
    assign if_req_ready_o            = slot_load[ARB_PORT_FETCH];
    assign d_req_ready_o             = slot_load[ARB_PORT_DATA];

    assign req_addr = (winner == ARB_PORT_DATA) ? d_req_addr_i : if_req_addr_i;
    assign req_size = (winner == ARB_PORT_DATA) ? d_req_size_i : WORD;
    assign req_we   = (winner == ARB_PORT_DATA) && d_req_we_i;
    assign aligned  = mem_is_aligned(req_addr[1:0], req_size);
    assign do_rd    = grant_any && aligned && !req_we;
    assign do_wr    = grant_any && aligned && req_we;

    assign memif.rd_addr   = do_rd ? req_addr : '0;
    assign memif.rd_size   = do_rd ? req_size : WORD;
    assign memif.wr_enable = do_wr;
    assign memif.wr_addr   = do_wr ? req_addr : '0;
    assign memif.wr_size   = do_wr ? req_size : WORD;
    assign memif.wr_data   = do_wr ? d_req_wdata_i : '0;

    // Stores and misaligned accesses return zero data.
    assign load_rdata = do_rd ? (memif.rd_data & DATA_W'(mem_size_mask(req_size))) : '0;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_slot
        mem_resp_slot #(.DATA_W(DATA_W)) u_slot (
            .clk_i      (clk_i),
            .reset_n_i  (reset_n_i),
            .load       (slot_load[p]),
            .load_rdata (load_rdata),
            .load_err   (!aligned),
            .resp_ready (resp_ready[p]),
            .valid      (slot_valid[p]),
            .rdata      (slot_rdata[p]),
            .err        (slot_err[p]),
            .can_accept (slot_can[p])
        );
    end

    assign if_resp_valid_o = slot_valid[ARB_PORT_FETCH];
    assign if_resp_rdata_o = slot_rdata[ARB_PORT_FETCH];
    assign if_resp_err_o   = slot_err[ARB_PORT_FETCH];
    assign d_resp_valid_o  = slot_valid[ARB_PORT_DATA];
    assign d_resp_rdata_o  = slot_rdata[ARB_PORT_DATA];
    assign d_resp_err_o    = slot_err[ARB_PORT_DATA];

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester front end for the single-ported `memory` block. It arbitrates between the instruction-fetch port and the load/store data port and checks alignment. It drives `mem_if` toward memory and returns registered responses with a valid/ready handshake. It sits between the core's fetch/LSU stages and `memory`, and allows one access in flight per cycle.

## Interface
Parameters:
- `ADDR_W`, 32, address width of both requesters and `mem_if`.
- `DATA_W`, 32, data width; only 32 is supported.

Ports:
- `clk_i` in 1: clock; all state updates on posedge.
- `reset_n_i` in 1: asynchronous, active-low reset.
- `if_req_valid_i` in 1: fetch request valid; fetch is read-only, word size.
- `if_req_ready_o` out 1: fetch request accepted this cycle.
- `if_req_addr_i` in ADDR_W: fetch address.
- `if_resp_valid_o` out 1: fetch response valid.
- `if_resp_ready_i` in 1: fetch response consumed.
- `if_resp_rdata_o` out DATA_W: fetched word.
- `if_resp_err_o` out 1: fetch misaligned.
- `d_req_valid_i` in 1: data request valid.
- `d_req_ready_o` out 1: data request accepted.
- `d_req_addr_i` in ADDR_W: data address.
- `d_req_size_i` in mem_access_size_t: BYTE, HALF or WORD.
- `d_req_we_i` in 1: 1 = store, 0 = load.
- `d_req_wdata_i` in DATA_W: store data, low-aligned.
- `d_resp_valid_o` out 1: data response valid; asserted for loads and stores.
- `d_resp_ready_i` in 1: data response consumed.
- `d_resp_rdata_o` out DATA_W: load data, zero-extended per size; 0 for stores.
- `d_resp_err_o` out 1: data access misaligned.
- `memif` mem_if.slave: toward `memory`; read data is combinational, write commits on posedge.

## Operation
- **Response slots:** one per port, each holding `valid`, `rdata` and `err`. A port may accept a request when its slot is empty, or when its slot is valid and its `resp_ready_i` is high in the same cycle.
- **Eligibility:** a port is eligible when `req_valid_i` is high and it may accept.
- **Selection:** at most one port wins per cycle.
  - If only one port is eligible, it wins.
  - If both are eligible, the winner follows the arbitration policy in Configuration.
  - The winner's `req_ready_o` is 1; the loser's is 0.
- **Alignment:**
  - WORD requires `addr[1:0]==0`.
  - HALF requires `addr[0]==0`.
  - BYTE is always aligned.
  - Fetch is always WORD.
- **Accepted aligned load/fetch:** drive `memif.rd_addr`/`rd_size` from the winner and capture `memif.rd_data` into the winner's slot at the edge.
- **Accepted aligned store:** drive `memif.wr_enable`=1, `wr_addr`, `wr_size` and `wr_data` in the accept cycle; the slot gets `rdata`=0.
- **Accepted misaligned request:** no memory access and `wr_enable` stays 0. The slot gets `err`=1 and `rdata`=0.
- **Idle memif:** when no port wins, `wr_enable`=0, addresses 0, sizes WORD.
- **Slot hold:** a slot stays valid with stable contents until `resp_ready_i`=1.
- **`last_grant`:** a register holding the most recent winner, of type arb_port_t.

## Timing
- Latency is 1 cycle: an accept at edge N gives `resp_valid_o` after edge N.
- Back-to-back throughput is one request per cycle per port, provided responses are consumed every cycle.
- `req_ready_o` is combinational from the valids, slot state and `resp_ready_i`; there is no combinational path from `memif.rd_data` to any output.
- A store is visible in memory to any read issued at least one cycle after its accept.
- Simultaneous accept and response consume on the same port: the slot reloads and `resp_valid_o` stays high.
- Reset:
  - All `resp_valid_o`, `resp_err_o` and `req_ready_o`=0 while `reset_n_i`=0.
  - `rdata` resets to 0 and `last_grant` to FETCH.
  - A reset mid-operation drops pending responses; a store accepted before the reset edge has already committed.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined: on a tie, the port not equal to `last_grant` wins, so ties alternate starting with DATA after reset.
- Undefined: DATA always wins ties and `last_grant` is unused; fetch can starve under continuous data traffic, which is acceptable.

## Structure
- `definitions` package gains:
  - `typedef enum logic {ARB_PORT_FETCH, ARB_PORT_DATA} arb_port_t`.
  - A `mem_is_aligned(addr, size)` function.
- `mem_access_size_t` is reused unchanged.
- One sub-module, `mem_resp_slot`: the per-port response register with its valid/ready hold logic, instantiated twice.

## Test plan
- Fetch word read at 0x100 (memory holds 0xDEADBEEF): fetch request accepted at cycle 0 -> `if_resp_valid_o` at cycle 1 with 0xDEADBEEF and err=0.
- Data store HALF 0xABCD at 0x202, then data load BYTE at 0x203 on the next cycle -> load response rdata=0x000000AB.
- Both valid every cycle, responses always ready:
  - With `MEM_ARB_ROUND_ROBIN_EN`, grants go D,F,D,F.
  - Without it, grants go D,D,D and fetch never receives ready.
- Data WORD store at 0x201 -> `d_resp_err_o`=1, `memif.wr_enable` never asserted, memory at 0x200..0x203 unchanged.
- Hold `d_resp_ready_i`=0 after a load -> the response stays stable, `d_req_ready_o`=0 for further data requests, and fetch requests are still accepted.
- Assert `reset_n_i`=0 while both slots are valid -> all resp_valid outputs drop to 0 immediately, without waiting for a clock edge.
